// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: opcode constants, instruction field positions and next-PC decode helpers.
`ifndef INSTR_FETCH_UNIT_DEFS
`define INSTR_FETCH_UNIT_DEFS
`define INSTR_W       28
`define OP_MSB        27
`define OP_LSB        24
`define IF_TARGET_MSB 23
`define IF_TARGET_LSB 16
`define NOP           4'h0
`define BLE           4'h9
`define JMP           4'hA
`define CALL          4'hB
`define RET           4'hC
`endif

package instr_fetch_unit_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = `INSTR_W;

    localparam logic [3:0] OPC_NOP  = `NOP;
    localparam logic [3:0] OPC_BLE  = `BLE;
    localparam logic [3:0] OPC_JMP  = `JMP;
    localparam logic [3:0] OPC_CALL = `CALL;
    localparam logic [3:0] OPC_RET  = `RET;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        NXT_SEQ,
        NXT_JMP,
        NXT_CALL,
        NXT_RET
    } next_sel_e;

    // BLE is resolved by execute, so it falls through to sequential here like any unknown op.
    function automatic next_sel_e decode_next(input instr_t instr);
        logic [3:0] op;
        next_sel_e  sel;
        op = instr[`OP_MSB:`OP_LSB];
        case (op)
            OPC_JMP:  sel = NXT_JMP;
            OPC_CALL: sel = NXT_CALL;
            OPC_RET:  sel = NXT_RET;
            default:  sel = NXT_SEQ;
        endcase
        return sel;
    endfunction

    function automatic pc_t target_of(input instr_t instr);
        return {8'd0, instr[`IF_TARGET_MSB:`IF_TARGET_LSB]};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data plus the decode-side instruction and redirect signals.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    pc_t        oAddress;
    instr_t     iInstruction;
    instr_t     oInstruction;
    logic       oValid;
    pc_t        oPC;
    logic       iStall;
    logic       iBranchTaken;
    logic [7:0] iBranchTarget;

    modport master (
        output oAddress, oInstruction, oValid, oPC,
        input  iInstruction, iStall, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oAddress, oInstruction, oValid, oPC,
        output iInstruction, iStall, iBranchTaken, iBranchTarget
    );
endinterface

// File: rtl/fetch_ras.sv
// Circular return-address stack; push/pop take effect on the clock edge, top is combinational.
// FETCH_RAS_ERR_EN adds a live-entry count and a sticky overflow/underflow flag.
module fetch_ras
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  pc_t  push_dat_i,
    output pc_t  top_o
`ifdef FETCH_RAS_ERR_EN
    ,
    output logic err_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    pc_t              stack_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;

    // ptr points at the next free slot, so the top lives one below it (wrapping).
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_o   = stack_q[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_i) begin
            stack_q[ptr_q] <= push_dat_i;
            ptr_q          <= ptr_q + PTR_W'(1);
        end else if (pop_i) begin
            ptr_q <= top_idx;
        end
    end

`ifdef FETCH_RAS_ERR_EN
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] live_q;
    logic             err_q;

    // The count saturates so it keeps tracking real occupancy while ptr wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            err_q  <= 1'b0;
        end else if (push_i) begin
            if (live_q == CNT_W'(DEPTH)) begin
                err_q <= 1'b1;
            end else begin
                live_q <= live_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (live_q == '0) begin
                err_q <= 1'b1;
            end else begin
                live_q <= live_q - CNT_W'(1);
            end
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, registers ROM data for decode, resolves JMP/CALL/RET via a local RAS.
// Optional feature macro: FETCH_RAS_ERR_EN (adds sticky oRasError).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          RAS_DEPTH = 8,
    parameter logic [15:0] RESET_PC  = 16'd0
) (
    input  logic Clock,
    input  logic Reset,
    instr_fetch_unit_if.master bus
`ifdef FETCH_RAS_ERR_EN
    ,
    output logic oRasError
`endif
);

    pc_t    pc_q, pc_d;
    instr_t instr_q, instr_d;
    logic   vld_q, vld_d;
    pc_t    opc_q, opc_d;

    logic   ras_push;
    logic   ras_pop;
    pc_t    ras_top;
    pc_t    pc_inc;

    assign pc_inc = pc_q + 16'd1;

    // A taken branch outranks a stall: the redirect must land even while decode is frozen.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        opc_d    = opc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (bus.iBranchTaken) begin
            pc_d  = {8'd0, bus.iBranchTarget};
            vld_d = 1'b0;
        end else if (!bus.iStall) begin
            instr_d = bus.iInstruction;
            opc_d   = pc_q;
            vld_d   = 1'b1;
            case (decode_next(bus.iInstruction))
                NXT_JMP: begin
                    pc_d = target_of(bus.iInstruction);
                end
                NXT_CALL: begin
                    pc_d     = target_of(bus.iInstruction);
                    ras_push = 1'b1;
                end
                NXT_RET: begin
                    pc_d    = ras_top;
                    ras_pop = 1'b1;
                end
                default: begin
                    pc_d = pc_inc;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= {OPC_NOP, 24'd0};
            vld_q   <= 1'b0;
            opc_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            opc_q   <= opc_d;
        end
    end

    fetch_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk       (Clock),
        .rst       (Reset),
        .push_i    (ras_push),
        .pop_i     (ras_pop),
        .push_dat_i(pc_inc),
        .top_o     (ras_top)
`ifdef FETCH_RAS_ERR_EN
        ,
        .err_o     (oRasError)
`endif
    );

    assign bus.oAddress     = pc_q;
    assign bus.oInstruction = instr_q;
    assign bus.oValid       = vld_q;
    assign bus.oPC          = opc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: address sequences per scenario, queued output expectations.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    typedef struct packed {
        logic   vld;
        pc_t    pc;
        instr_t instr;
    } out_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    instr_fetch_unit_if bus();
    instr_fetch_unit_if bus2();

    instr_t rom [65536];
    assign bus.iInstruction  = rom[bus.oAddress];
    assign bus2.iInstruction = {OPC_NOP, 24'd0};

`ifdef FETCH_RAS_ERR_EN
    logic ras_err;
    logic ras_err2;
`endif

    instr_fetch_unit #(.RAS_DEPTH(8), .RESET_PC(16'd0)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .bus      (bus)
`ifdef FETCH_RAS_ERR_EN
        ,
        .oRasError(ras_err)
`endif
    );

    instr_fetch_unit #(.RAS_DEPTH(8), .RESET_PC(16'hFFFF)) dut_wrap (
        .Clock    (Clock),
        .Reset    (Reset),
        .bus      (bus2)
`ifdef FETCH_RAS_ERR_EN
        ,
        .oRasError(ras_err2)
`endif
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_out[$];
    out_t last;

    function automatic instr_t mk(input logic [3:0] op, input logic [7:0] tgt);
        return {op, tgt, 16'd0};
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        bus.iStall = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchTarget = 8'd0;
        for (int i = 0; i < 65536; i++) rom[i] = {OPC_NOP, 8'h00, 16'(i)};
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        exp_out.delete();
        last = '{vld: 1'b0, pc: 16'd0, instr: {OPC_NOP, 24'd0}};
        exp_out.push_back(last);
    endtask

    // Drives one edge and queues what the registered outputs must show after it.
    task automatic step(input logic stall, input logic br, input logic [7:0] tgt, input pc_t a);
        bus.iStall = stall;
        bus.iBranchTaken = br;
        bus.iBranchTarget = tgt;
        if (br) last.vld = 1'b0;
        else if (!stall) last = '{vld: 1'b1, pc: a, instr: rom[a]};
        exp_out.push_back(last);
        @(posedge Clock);
        @(negedge Clock);
        bus.iStall = 1'b0;
        bus.iBranchTaken = 1'b0;
    endtask

    task automatic test_reset();
        int   seq[4] = '{0, 1, 2, 3};
        out_t o;
        do_reset();
        n_cmp++; if (bus.oAddress !== 16'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", bus.oAddress); end
        n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.oValid); end
        n_cmp++; if (bus.oPC !== 16'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0000", bus.oPC); end
        n_cmp++; if (bus.oInstruction !== {OPC_NOP, 24'd0}) begin n_bad++; $display("FAIL rst_instr: got %h want %h", bus.oInstruction, {OPC_NOP, 24'd0}); end
`ifdef FETCH_RAS_ERR_EN
        n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL rst_raserr: got %b want 0", ras_err); end
`endif
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(seq[i])) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(seq[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL seq_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            step(1'b0, 1'b0, 8'd0, 16'(seq[i]));
        end
    endtask

    task automatic test_jmp();
        int   seq[7] = '{0, 1, 2, 3, 4, 10, 11};
        out_t o;
        do_reset();
        rom[4] = mk(OPC_JMP, 8'd10);
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(seq[i])) begin n_bad++; $display("FAIL jmp_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(seq[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL jmp_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            step(1'b0, 1'b0, 8'd0, 16'(seq[i]));
        end
    endtask

    task automatic test_call_ret();
        int   seq[16] = '{0, 1, 2, 3, 4, 10, 11, 18, 12, 30, 40, 50, 41, 31, 13, 14};
        out_t o;
        do_reset();
        rom[4]  = mk(OPC_JMP, 8'd10);
        rom[11] = mk(OPC_CALL, 8'd18);
        rom[18] = mk(OPC_RET, 8'd0);
        rom[12] = mk(OPC_CALL, 8'd30);
        rom[30] = mk(OPC_CALL, 8'd40);
        rom[40] = mk(OPC_CALL, 8'd50);
        rom[50] = mk(OPC_RET, 8'd0);
        rom[41] = mk(OPC_RET, 8'd0);
        rom[31] = mk(OPC_RET, 8'd0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(seq[i])) begin n_bad++; $display("FAIL call_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(seq[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL call_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            step(1'b0, 1'b0, 8'd0, 16'(seq[i]));
        end
`ifdef FETCH_RAS_ERR_EN
        n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL call_raserr: got %b want 0", ras_err); end
`endif
    endtask

    task automatic test_stall_branch();
        int   seq[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 20, 21};
        out_t o;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(seq[i])) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(seq[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL stall_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            step((i >= 7 && i <= 10), (i == 10), 8'd20, 16'(seq[i]));
        end
    endtask

    task automatic test_ras_overflow();
        int   seq[19] = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90, 81, 71, 61, 51, 41, 31, 21, 11, 81};
        out_t o;
        do_reset();
        for (int k = 0; k < 9; k++) rom[10*k] = mk(OPC_CALL, 8'(10*(k+1)));
        rom[90] = mk(OPC_RET, 8'd0);
        for (int k = 1; k < 9; k++) rom[10*k+1] = mk(OPC_RET, 8'd0);
        for (int i = 0; i < 19; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(seq[i])) begin n_bad++; $display("FAIL ras_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(seq[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL ras_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
`ifdef FETCH_RAS_ERR_EN
            n_cmp++; if (ras_err !== (i >= 9)) begin n_bad++; $display("FAIL ras_err[%0d]: got %b want %b", i, ras_err, (i >= 9)); end
`endif
            step(1'b0, 1'b0, 8'd0, 16'(seq[i]));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_cmp++; if (bus2.oAddress !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_rstpc: got %h want ffff", bus2.oAddress); end
        @(posedge Clock);
        @(negedge Clock);
        n_cmp++; if (bus2.oAddress !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr: got %h want 0000", bus2.oAddress); end
        n_cmp++; if (bus2.oPC !== 16'hFFFF || bus2.oValid !== 1'b1) begin n_bad++; $display("FAIL wrap_out: got v%b pc %h want v1 pc ffff", bus2.oValid, bus2.oPC); end
    endtask

    task automatic test_reset_mid_call();
        int   pre[2]  = '{0, 40};
        int   post[3] = '{0, 0, 0};
        out_t o;
        do_reset();
        rom[0]  = mk(OPC_CALL, 8'd40);
        rom[40] = mk(OPC_CALL, 8'd50);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(pre[i])) begin n_bad++; $display("FAIL mid_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(pre[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL mid_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            if (i == 0) step(1'b0, 1'b0, 8'd0, 16'(pre[i]));
        end
        // Reset lands while the second CALL is on the bus, before its push edge.
        Reset = 1'b1;
        #1;
        n_cmp++; if (bus.oAddress !== 16'd0 || bus.oValid !== 1'b0 || bus.oPC !== 16'd0) begin n_bad++; $display("FAIL mid_rst: got addr %h v%b pc %h want 0000 v0 0000", bus.oAddress, bus.oValid, bus.oPC); end
`ifdef FETCH_RAS_ERR_EN
        n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", ras_err); end
`endif
        rom[0] = mk(OPC_RET, 8'd0);
        @(negedge Clock);
        Reset = 1'b0;
        exp_out.delete();
        last = '{vld: 1'b0, pc: 16'd0, instr: {OPC_NOP, 24'd0}};
        exp_out.push_back(last);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.oAddress !== 16'(post[i])) begin n_bad++; $display("FAIL mid_post_addr[%0d]: got %h want %h", i, bus.oAddress, 16'(post[i])); end
            o = exp_out.pop_front();
            n_cmp++; if (out_t'({bus.oValid, bus.oPC, bus.oInstruction}) !== o) begin n_bad++; $display("FAIL mid_post_out[%0d]: got v%b pc %h ins %h want v%b pc %h ins %h", i, bus.oValid, bus.oPC, bus.oInstruction, o.vld, o.pc, o.instr); end
            step(1'b0, 1'b0, 8'd0, 16'(post[i]));
        end
    endtask

    initial begin
        bus2.iStall = 1'b0;
        bus2.iBranchTaken = 1'b0;
        bus2.iBranchTarget = 8'd0;
        test_reset();
        test_jmp();
        test_call_ret();
        test_stall_branch();
        test_ras_overflow();
        test_wrap();
        test_reset_mid_call();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
